result_filter: RTL and testbench

RESULT_FILTER -- requirements
Module: result_filter

---
 rtl/result_filter.sv | 202 ++++++++++++++++++++
 tb/tb_result_filter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_filter.sv
// Result filter: confirms a colour/shape pair once it has been seen on
// N_CONFIRM consecutive frames, or reports a give-up after MAX_FRAMES frames.
// The result is held until the consumer acknowledges it.
module result_filter #(
  parameter int N_CONFIRM  = 3,
  parameter int MAX_FRAMES = 30
) (
  input  logic       Pclock,
  input  logic       Reset,
  input  logic       Vsync,
  input  logic [1:0] Promedio,
  input  logic [1:0] Forma,
  input  logic       Start,
  input  logic       Ack,
  output logic       Busy,
  output logic       Valid,
  output logic [1:0] Color,
  output logic [1:0] Figura,
  output logic       Timeout,
  output logic [7:0] FrameCount
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] N_CONF_C = 4'(N_CONFIRM);
  localparam logic [7:0] MAX_C    = 8'(MAX_FRAMES);

  state_t      state_r;
  state_t      state_s;

  logic        vsync_q_r;
  logic        fe_s;
  logic        fe_d_r;
  logic [3:0]  sample_s;

  logic [3:0]  cand_r;
  logic        cand_vld_r;
  logic [3:0]  match_r;

  logic [3:0]  cand_s;
  logic        cand_vld_s;
  logic [3:0]  match_s;
  logic        busy_s;
  logic        valid_s;
  logic [1:0]  color_s;
  logic [1:0]  figura_s;
  logic        timeout_s;
  logic [7:0]  frame_count_s;

  logic        confirm_s;
  logic        give_up_s;

  // Frame-end pulse on the Vsync rising edge; the capture stage updates
  // Promedio/Forma on that cycle, so we sample one cycle later via fe_d_r.
  assign fe_s     = Vsync & ~vsync_q_r;
  assign sample_s = {Promedio, Forma};

  // Confirmation has priority over the frame limit when both occur together.
  assign confirm_s = (state_r == ST_ACQUIRE) && (match_r == N_CONF_C);
  assign give_up_s = (state_r == ST_ACQUIRE) && !confirm_s && (FrameCount >= MAX_C);

  // Vsync edge detector and sample-strobe delay registers
  always_ff @(posedge Pclock or posedge Reset) begin
    if (Reset) begin
      vsync_q_r <= 1'b0;
      fe_d_r    <= 1'b0;
    end else begin
      vsync_q_r <= Vsync;
      fe_d_r    <= fe_s;
    end
  end

  // FSM state register
  always_ff @(posedge Pclock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) state_s = ST_ACQUIRE;
        else       state_s = ST_IDLE;
      end
      ST_ACQUIRE: begin
        if (confirm_s || give_up_s) state_s = ST_HOLD;
        else                        state_s = ST_ACQUIRE;
      end
      ST_HOLD: begin
        if (Ack) state_s = ST_IDLE;
        else     state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output/datapath next values; all outputs are registered below
  always_comb begin
    cand_s        = cand_r;
    cand_vld_s    = cand_vld_r;
    match_s       = match_r;
    busy_s        = Busy;
    valid_s       = Valid;
    color_s       = Color;
    figura_s      = Figura;
    timeout_s     = Timeout;
    frame_count_s = FrameCount;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          cand_s        = 4'd0;
          cand_vld_s    = 1'b0;
          match_s       = 4'd0;
          frame_count_s = 8'd0;
          busy_s        = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (confirm_s) begin
          color_s   = cand_r[3:2];
          figura_s  = cand_r[1:0];
          timeout_s = 1'b0;
          valid_s   = 1'b1;
          busy_s    = 1'b0;
        end else if (give_up_s) begin
          color_s   = 2'b00;
          figura_s  = 2'b00;
          timeout_s = 1'b1;
          valid_s   = 1'b1;
          busy_s    = 1'b0;
        end else if (fe_d_r) begin
          if (FrameCount == 8'd255) frame_count_s = 8'd255;
          else                      frame_count_s = FrameCount + 8'd1;
          if (sample_s[3:2] == 2'b00) begin
            match_s    = 4'd0;
            cand_vld_s = 1'b0;
          end else if (cand_vld_r && (sample_s == cand_r)) begin
            match_s = match_r + 4'd1;
          end else begin
            cand_s     = sample_s;
            cand_vld_s = 1'b1;
            match_s    = 4'd1;
          end
        end else begin
          busy_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Ack) valid_s = 1'b0;
        else     valid_s = 1'b1;
      end
      default: begin
        cand_s        = 4'd0;
        cand_vld_s    = 1'b0;
        match_s       = 4'd0;
        busy_s        = 1'b0;
        valid_s       = 1'b0;
        color_s       = 2'b00;
        figura_s      = 2'b00;
        timeout_s     = 1'b0;
        frame_count_s = 8'd0;
      end
    endcase
  end

  // Candidate, match counter and registered result outputs
  always_ff @(posedge Pclock or posedge Reset) begin
    if (Reset) begin
      cand_r     <= 4'd0;
      cand_vld_r <= 1'b0;
      match_r    <= 4'd0;
      Busy       <= 1'b0;
      Valid      <= 1'b0;
      Color      <= 2'b00;
      Figura     <= 2'b00;
      Timeout    <= 1'b0;
      FrameCount <= 8'd0;
    end else begin
      cand_r     <= cand_s;
      cand_vld_r <= cand_vld_s;
      match_r    <= match_s;
      Busy       <= busy_s;
      Valid      <= valid_s;
      Color      <= color_s;
      Figura     <= figura_s;
      Timeout    <= timeout_s;
      FrameCount <= frame_count_s;
    end
  end

endmodule

// File: tb/tb_result_filter.sv
// Bench for result_filter: table of frame sequences with expected results
// (scoreboard queue), plus hand-written latency, hold and reset sequences.
module tb_result_filter;

  logic       Pclock = 1'b0;
  logic       Reset;
  logic       Vsync;
  logic [1:0] Promedio;
  logic [1:0] Forma;
  logic       start_a, ack_a, start_b, ack_b;

  logic       busy_a, valid_a, timeout_a;
  logic [1:0] color_a, figura_a;
  logic [7:0] fc_a;
  logic       busy_b, valid_b, timeout_b;
  logic [1:0] color_b, figura_b;
  logic [7:0] fc_b;

  logic       sel;
  logic       cur_busy, cur_valid, cur_to;
  logic [1:0] cur_col, cur_fig;
  logic [7:0] cur_fc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] col;
    logic [1:0] fig;
    logic       to;
    logic [7:0] fc;
  } exp_t;

  typedef struct {
    logic        dsel;
    int          nf;
    logic [23:0] frames;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  always #5 Pclock = ~Pclock;

  result_filter dut_a (
    .Pclock(Pclock), .Reset(Reset), .Vsync(Vsync), .Promedio(Promedio), .Forma(Forma),
    .Start(start_a), .Ack(ack_a), .Busy(busy_a), .Valid(valid_a), .Color(color_a),
    .Figura(figura_a), .Timeout(timeout_a), .FrameCount(fc_a)
  );

  result_filter #(.N_CONFIRM(3), .MAX_FRAMES(4)) dut_b (
    .Pclock(Pclock), .Reset(Reset), .Vsync(Vsync), .Promedio(Promedio), .Forma(Forma),
    .Start(start_b), .Ack(ack_b), .Busy(busy_b), .Valid(valid_b), .Color(color_b),
    .Figura(figura_b), .Timeout(timeout_b), .FrameCount(fc_b)
  );

  assign cur_busy  = sel ? busy_b    : busy_a;
  assign cur_valid = sel ? valid_b   : valid_a;
  assign cur_to    = sel ? timeout_b : timeout_a;
  assign cur_col   = sel ? color_b   : color_a;
  assign cur_fig   = sel ? figura_b  : figura_a;
  assign cur_fc    = sel ? fc_b      : fc_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic frame(input logic [3:0] code);
    @(negedge Pclock);
    Promedio = code[3:2];
    Forma    = code[1:0];
    Vsync    = 1'b1;
    repeat (3) @(negedge Pclock);
    Vsync = 1'b0;
    repeat (4) @(negedge Pclock);
  endtask

  task automatic pulse_start(input logic s);
    @(negedge Pclock);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge Pclock);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_ack(input logic s);
    @(negedge Pclock);
    if (s) ack_b = 1'b1; else ack_a = 1'b1;
    @(negedge Pclock);
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (cur_valid) got = 1'b1;
      else @(negedge Pclock);
    end
    chk({name, "_valid_seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_color"},   32'(cur_col), 32'(e.col));
      chk({name, "_figura"},  32'(cur_fig), 32'(e.fig));
      chk({name, "_timeout"}, 32'(cur_to),  32'(e.to));
      chk({name, "_fc"},      32'(cur_fc),  32'(e.fc));
      chk({name, "_busy"},    32'(cur_busy), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] code;
    exp_t       e;

    vecs[0] = '{1'b0, 3, 24'h666000, '{2'b01, 2'b10, 1'b0, 8'd3}};
    vecs[1] = '{1'b0, 5, 24'h66DDD0, '{2'b11, 2'b01, 1'b0, 8'd5}};
    vecs[2] = '{1'b0, 5, 24'h909990, '{2'b10, 2'b01, 1'b0, 8'd5}};
    vecs[3] = '{1'b0, 4, 24'h455500, '{2'b01, 2'b01, 1'b0, 8'd4}};
    vecs[4] = '{1'b0, 3, 24'h444000, '{2'b01, 2'b00, 1'b0, 8'd3}};
    vecs[5] = '{1'b0, 4, 24'h0FFF00, '{2'b11, 2'b11, 1'b0, 8'd4}};
    vecs[6] = '{1'b1, 4, 24'h595900, '{2'b00, 2'b00, 1'b1, 8'd4}};
    vecs[7] = '{1'b1, 4, 24'h599900, '{2'b10, 2'b01, 1'b0, 8'd4}};
    vecs[8] = '{1'b1, 4, 24'h000000, '{2'b00, 2'b00, 1'b1, 8'd4}};
    vecs[9] = '{1'b0, 6, 24'h59F555, '{2'b01, 2'b01, 1'b0, 8'd6}};

    sel      = 1'b0;
    Reset    = 1'b1;
    Vsync    = 1'b0;
    Promedio = 2'b00;
    Forma    = 2'b00;
    start_a  = 1'b0;
    ack_a    = 1'b0;
    start_b  = 1'b0;
    ack_b    = 1'b0;
    repeat (3) @(negedge Pclock);
    chk("reset_a", 32'({busy_a, valid_a, color_a, figura_a, timeout_a, fc_a}), 32'd0);
    chk("reset_b", 32'({busy_b, valid_b, color_b, figura_b, timeout_b, fc_b}), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Pclock);

    // Table-driven runs
    for (int v = 0; v < 10; v++) begin
      sel = vecs[v].dsel;
      sb.push_back(vecs[v].exp);
      pulse_start(sel);
      chk($sformatf("v%0d_busy_start", v), 32'(cur_busy), 32'd1);
      for (int f = 0; f < vecs[v].nf; f++) begin
        code = vecs[v].frames[23 - 4*f -: 4];
        frame(code);
        if (f < vecs[v].nf - 1)
          chk($sformatf("v%0d_f%0d_early_valid", v, f), 32'(cur_valid), 32'd0);
      end
      wait_valid($sformatf("v%0d", v));
      check_result($sformatf("v%0d", v));
      pulse_ack(sel);
      chk($sformatf("v%0d_ack_valid", v), 32'(cur_valid), 32'd0);
      chk($sformatf("v%0d_ack_busy", v), 32'(cur_busy), 32'd0);
      chk($sformatf("v%0d_ack_fc_kept", v), 32'(cur_fc), 32'(vecs[v].exp.fc));
      chk($sformatf("v%0d_ack_to_kept", v), 32'(cur_to), 32'(vecs[v].exp.to));
    end

    // Exact latency, Start/Ack ignored while acquiring, hold stability
    sel = 1'b0;
    e = '{2'b01, 2'b10, 1'b0, 8'd3};
    sb.push_back(e);
    pulse_start(1'b0);
    frame(4'h6);
    pulse_start(1'b0);
    pulse_ack(1'b0);
    frame(4'h6);
    @(negedge Pclock);
    Promedio = 2'b01;
    Forma    = 2'b10;
    Vsync    = 1'b1;
    @(negedge Pclock);
    chk("lat_fe_d_cycle", 32'(valid_a), 32'd0);
    @(negedge Pclock);
    chk("lat_count_cycle", 32'(valid_a), 32'd0);
    @(negedge Pclock);
    chk("lat_valid_cycle", 32'(valid_a), 32'd1);
    Vsync = 1'b0;
    check_result("lat");
    for (int i = 0; i < 100; i++) begin
      @(negedge Pclock);
      start_a  = (i % 10 == 0);
      Vsync    = ((i % 20) < 5);
      Promedio = 2'b11;
      Forma    = 2'b11;
      chk("hold_stable", 32'({valid_a, color_a, figura_a, timeout_a, fc_a, busy_a}),
          32'({1'b1, 2'b01, 2'b10, 1'b0, 8'd3, 1'b0}));
    end
    @(negedge Pclock);
    start_a = 1'b1;
    ack_a   = 1'b1;
    Vsync   = 1'b0;
    @(negedge Pclock);
    start_a = 1'b0;
    ack_a   = 1'b0;
    chk("startack_valid", 32'(valid_a), 32'd0);
    chk("startack_busy", 32'(busy_a), 32'd0);
    chk("startack_kept", 32'({color_a, figura_a, fc_a}), 32'({2'b01, 2'b10, 8'd3}));
    repeat (5) @(negedge Pclock);
    chk("startack_dropped", 32'(busy_a), 32'd0);

    // Reset between frames 2 and 3; no result without a new Start
    pulse_start(1'b0);
    frame(4'h6);
    frame(4'h6);
    @(negedge Pclock);
    Reset = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({busy_a, valid_a, color_a, figura_a, timeout_a, fc_a}), 32'd0);
    @(negedge Pclock);
    Reset = 1'b0;
    for (int f = 0; f < 3; f++) frame(4'h6);
    chk("rst_nostart_valid", 32'(valid_a), 32'd0);
    chk("rst_nostart_busy", 32'(busy_a), 32'd0);
    chk("rst_nostart_fc", 32'(fc_a), 32'd0);
    e = '{2'b11, 2'b10, 1'b0, 8'd3};
    sb.push_back(e);
    pulse_start(1'b0);
    for (int f = 0; f < 3; f++) frame(4'hE);
    wait_valid("rst_recover");
    check_result("rst_recover");
    pulse_ack(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
